// File: rtl/user_ram_bus_bridge.sv
// Native memory bus slave driving a single-port word RAM; partial writes run as read-modify-write.
// Optional misaligned-access error path with sticky err_o: define USER_RAM_BRIDGE_ERR_EN.
module user_ram_bus_bridge #(
    parameter int unsigned ADDR_BIT  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mem_valid_i,
    input  logic [31:0]         mem_addr_i,
    input  logic [31:0]         mem_wdata_i,
    input  logic [3:0]          mem_wstrb_i,
    output logic                mem_ready_o,
    output logic [31:0]         mem_rdata_o,
    output logic                ram_wr_en_o,
    output logic                ram_rd_en_o,
    output logic [ADDR_BIT-1:0] ram_addr_o,
    output logic [31:0]         ram_di_o,
    input  logic [31:0]         ram_do_i
`ifdef USER_RAM_BRIDGE_ERR_EN
    ,
    output logic                err_o
`endif
);

`ifdef USER_RAM_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR, ACK} state_t;

    state_t              state, state_nx;
    logic                sel;
    logic                misalign;
    logic [ADDR_BIT-1:0] addr_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic [31:0]         rdata_q;
    logic [31:0]         merge_q;
    logic                bad_q;

    assign sel      = mem_valid_i && (mem_addr_i[31:ADDR_BIT+2] == BASE_ADDR[31:ADDR_BIT+2]);
    assign misalign = ERR_EN && (mem_addr_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (sel) begin
                    if (misalign)                state_nx = ACK;
                    else if (mem_wstrb_i == 4'hF) state_nx = WR;
                    else                          state_nx = RD_ISSUE;
                end
            end
            RD_ISSUE:   state_nx = RD_CAPTURE;
            RD_CAPTURE: state_nx = (wstrb_q == 4'h0) ? ACK : WR;
            WR:         state_nx = ACK;
            ACK:        state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            if (state == IDLE && sel) begin
                addr_q  <= mem_addr_i[ADDR_BIT+1:2];
                wdata_q <= mem_wdata_i;
                wstrb_q <= mem_wstrb_i;
                bad_q   <= misalign;
            end
            if (state == RD_CAPTURE) begin
                if (wstrb_q == 4'h0) begin
                    rdata_q <= ram_do_i;
                end else begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        merge_q[8*k +: 8] <= wstrb_q[k] ? wdata_q[8*k +: 8] : ram_do_i[8*k +: 8];
                    end
                end
            end
        end
    end

`ifdef USER_RAM_BRIDGE_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (state == IDLE && sel && misalign) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

    // Address is held from the IDLE latch, so it stays stable through WR/ACK.
    always_comb begin
        mem_ready_o = 1'b0;
        mem_rdata_o = '0;
        ram_wr_en_o = 1'b0;
        ram_rd_en_o = 1'b0;
        ram_addr_o  = addr_q;
        ram_di_o    = '0;
        unique case (state)
            RD_ISSUE, RD_CAPTURE: ram_rd_en_o = 1'b1;
            WR: begin
                ram_wr_en_o = 1'b1;
                ram_di_o    = (wstrb_q == 4'hF) ? wdata_q : merge_q;
            end
            ACK: begin
                mem_ready_o = 1'b1;
                if (wstrb_q == 4'h0) begin
                    mem_rdata_o = bad_q ? 32'hDEAD_BEEF : rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_user_ram_bus_bridge.sv
// Directed bench for user_ram_bus_bridge with a registered-read RAM model.
// Covers latency, RMW merge, window boundary, mid-transaction reset, back-to-back and misaligned access.
module tb_user_ram_bus_bridge;

    localparam int unsigned AB   = 8;
    localparam logic [31:0] BASE = 32'h0002_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          ram_wr_en;
    logic          ram_rd_en;
    logic [AB-1:0] ram_addr;
    logic [31:0]   ram_di;
    logic [31:0]   ram_do;
`ifdef USER_RAM_BRIDGE_ERR_EN
    logic          err;
`endif

    int tests = 0;
    int fails = 0;

    int          wr_cnt = 0, rd_cnt = 0, rdy_cnt = 0, overlap = 0;
    logic [AB-1:0] last_wr_addr;
    logic [31:0]   last_wr_di;
    logic [31:0]   ram [0:(1<<AB)-1];

    always #5 clk = ~clk;

    user_ram_bus_bridge #(.ADDR_BIT(AB), .BASE_ADDR(BASE)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .mem_valid_i (mem_valid),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_ready_o (mem_ready),
        .mem_rdata_o (mem_rdata),
        .ram_wr_en_o (ram_wr_en),
        .ram_rd_en_o (ram_rd_en),
        .ram_addr_o  (ram_addr),
        .ram_di_o    (ram_di),
        .ram_do_i    (ram_do)
`ifdef USER_RAM_BRIDGE_ERR_EN
        ,
        .err_o       (err)
`endif
    );

    // RAM model: data appears the cycle after rd_en, garbage otherwise.
    always @(posedge clk) begin
        ram_do <= ram_rd_en ? ram[ram_addr] : 32'h0BAD_0BAD;
        if (ram_wr_en) ram[ram_addr] <= ram_di;
    end

    always @(posedge clk) begin
        if (ram_wr_en) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= ram_addr;
            last_wr_di   <= ram_di;
        end
        if (ram_rd_en)              rd_cnt  <= rd_cnt + 1;
        if (mem_ready)              rdy_cnt <= rdy_cnt + 1;
        if (ram_rd_en && ram_wr_en) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 with valid dropped after the ready cycle.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat, output logic [15:0] pat);
        bit got = 0;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        pat = '0; lat = 0; rd = '0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); @(negedge clk);
            pat = {pat[13:0], ram_rd_en, ram_wr_en};
            if (mem_ready) begin
                got = 1; lat = n + 1; rd = mem_rdata;
            end
        end
        check("ready_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_wstrb = 4'h0;
    endtask

    logic [31:0] rd;
    int          lat;
    logic [15:0] pat;
    int          s_wr, s_rd, s_rdy;

    initial begin
        rst_n = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_en", {30'd0, ram_rd_en, ram_wr_en}, 32'd0);
        check("rst_addr", {24'd0, ram_addr}, 32'd0);
        check("rst_di", ram_di, 32'd0);
`ifdef USER_RAM_BRIDGE_ERR_EN
        check("rst_err", {31'd0, err}, 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Full write then read back
        access(BASE + 32'h10, 32'h1234_5678, 4'hF, rd, lat, pat);
        check("fw_lat", lat, 2);
        check("fw_pat", {16'd0, pat}, 32'h4);
        check("fw_addr", {24'd0, last_wr_addr}, 32'd4);
        check("fw_di", last_wr_di, 32'h1234_5678);
        check("fw_rdata", rd, 32'd0);
        access(BASE + 32'h10, 32'h0, 4'h0, rd, lat, pat);
        check("rd_lat", lat, 3);
        check("rd_pat", {16'd0, pat}, 32'h28);
        check("rd_data", rd, 32'h1234_5678);

        // Partial write: read, read, write
        access(BASE + 32'h20, 32'hAABB_CCDD, 4'hF, rd, lat, pat);
        access(BASE + 32'h20, 32'h1122_3344, 4'b0101, rd, lat, pat);
        check("pw_lat", lat, 4);
        check("pw_pat", {16'd0, pat}, 32'hA4);
        check("pw_di", last_wr_di, 32'hAA22_CC44);
        check("pw_addr", {24'd0, last_wr_addr}, 32'd8);
        access(BASE + 32'h20, 32'h0, 4'h0, rd, lat, pat);
        check("pw_readback", rd, 32'hAA22_CC44);

        // Just past the window: ignored
        s_wr = wr_cnt; s_rd = rd_cnt; s_rdy = rdy_cnt;
        mem_valid = 1'b1; mem_addr = BASE + 32'h400; mem_wstrb = 4'h0;
        repeat (5) @(posedge clk);
        #1 mem_wstrb = 4'hF;
        repeat (5) @(posedge clk);
        #1 mem_valid = 1'b0; mem_wstrb = 4'h0;
        check("oow_ready", rdy_cnt - s_rdy, 0);
        check("oow_rd", rd_cnt - s_rd, 0);
        check("oow_wr", wr_cnt - s_wr, 0);

        // Last word of window
        access(BASE + 32'h3FC, 32'h5A5A_0FF0, 4'hF, rd, lat, pat);
        check("last_lat", lat, 2);
        check("last_addr", {24'd0, last_wr_addr}, 32'hFF);
        access(BASE + 32'h3FC, 32'h0, 4'h0, rd, lat, pat);
        check("last_data", rd, 32'h5A5A_0FF0);

        // Reset during RD_CAPTURE of a partial write
        access(BASE + 32'h40, 32'hCAFE_F00D, 4'hF, rd, lat, pat);
        mem_valid = 1'b1; mem_addr = BASE + 32'h40; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'b0011;
        @(posedge clk); @(posedge clk); #1;
        check("mid_rd_en", {31'd0, ram_rd_en}, 32'd1);
        s_wr = wr_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("mid_en", {30'd0, ram_rd_en, ram_wr_en}, 32'd0);
        check("mid_addr", {24'd0, ram_addr}, 32'd0);
        check("mid_ready", {31'd0, mem_ready}, 32'd0);
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        check("mid_no_wr", wr_cnt - s_wr, 0);
        @(posedge clk); #1;
        access(BASE + 32'h40, 32'h0, 4'h0, rd, lat, pat);
        check("mid_word", rd, 32'hCAFE_F00D);

        // Back-to-back reads
        access(BASE + 32'h0, 32'h1000_0000, 4'hF, rd, lat, pat);
        access(BASE + 32'h4, 32'h2000_0001, 4'hF, rd, lat, pat);
        access(BASE + 32'h8, 32'h3000_0002, 4'hF, rd, lat, pat);
        s_rdy = rdy_cnt;
        access(BASE + 32'h0, 32'h0, 4'h0, rd, lat, pat);
        check("b2b0", rd, 32'h1000_0000);
        check("b2b0_lat", lat, 3);
        access(BASE + 32'h4, 32'h0, 4'h0, rd, lat, pat);
        check("b2b1", rd, 32'h2000_0001);
        check("b2b1_lat", lat, 3);
        access(BASE + 32'h8, 32'h0, 4'h0, rd, lat, pat);
        check("b2b2", rd, 32'h3000_0002);
        check("b2b2_lat", lat, 3);
        @(posedge clk); #1;
        check("b2b_ready_cnt", rdy_cnt - s_rdy, 3);

`ifdef USER_RAM_BRIDGE_ERR_EN
        s_rd = rd_cnt; s_wr = wr_cnt;
        access(BASE + 32'h3, 32'h0, 4'h0, rd, lat, pat);
        check("err_rd_lat", lat, 1);
        check("err_rd_data", rd, 32'hDEAD_BEEF);
        check("err_set", {31'd0, err}, 32'd1);
        check("err_no_rd", rd_cnt - s_rd, 0);
        access(BASE + 32'h5, 32'h7777_7777, 4'hF, rd, lat, pat);
        check("err_wr_lat", lat, 1);
        check("err_no_wr", wr_cnt - s_wr, 0);
        check("err_held", {31'd0, err}, 32'd1);
        access(BASE + 32'h4, 32'h0, 4'h0, rd, lat, pat);
        check("err_word_kept", rd, 32'h2000_0001);
`else
        access(BASE + 32'h13, 32'h0, 4'h0, rd, lat, pat);
        check("mis_rd_lat", lat, 3);
        check("mis_rd_data", rd, 32'h1234_5678);
        access(BASE + 32'h6, 32'h0000_00EE, 4'b0001, rd, lat, pat);
        check("mis_wr_addr", {24'd0, last_wr_addr}, 32'd1);
        check("mis_wr_di", last_wr_di, 32'h2000_00EE);
`endif

        check("no_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/user_ram_bus_bridge.md
Name: user_ram_bus_bridge

Overview:
- Upstream stage for the user RAM: a CPU native memory bus slave (valid/ready, byte write strobes) driving the RAM's single-port word interface.
- The RAM port has no byte enables, so partial-word writes run as internal read-modify-write sequences.
- Sits between the SoC bus decode and the user RAM instance.
- Only accesses inside this block's address window are handled. All others are ignored, with no ready, for other slaves to answer.

Parameters:
- ADDR_BIT, 8: RAM word-address width; the window is 2^ADDR_BIT words.
- BASE_ADDR, 32'h0002_0000: byte base of the window; must be aligned to 2^(ADDR_BIT+2).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- mem_valid_i  in  1  bus request valid; held until mem_ready_o is seen.
- mem_addr_i  in  32  byte address.
- mem_wdata_i  in  32  write data.
- mem_wstrb_i  in  4  byte write strobes; 4'b0000 means read.
- mem_ready_o  out  1  one-cycle transfer-complete pulse.
- mem_rdata_o  out  32  read data, valid while mem_ready_o=1.
- ram_wr_en_o  out  1  RAM write enable.
- ram_rd_en_o  out  1  RAM read enable.
- ram_addr_o  out  ADDR_BIT  RAM word address.
- ram_di_o  out  32  RAM write data.
- ram_do_i  in  32  RAM read data: registered, valid the cycle after ram_rd_en_o is first asserted, and only while ram_rd_en_o stays high.
- err_o  out  1  sticky error flag; present only with USER_RAM_BRIDGE_ERR_EN.

Behaviour:
- Reset (rst_i=0, asynchronous, including mid-transaction):
  - State goes to IDLE.
  - All outputs go to 0: mem_ready_o, mem_rdata_o, ram_wr_en_o, ram_rd_en_o, ram_addr_o, ram_di_o, err_o.
  - Latched address, data and strobes are cleared. No partial write completes.
- Select: sel = mem_valid_i && mem_addr_i[31:ADDR_BIT+2] == BASE_ADDR[31:ADDR_BIT+2].
- Word address: mem_addr_i[ADDR_BIT+1:2].
- States: IDLE, RD_ISSUE, RD_CAPTURE, WR, ACK.
- IDLE:
  - On sel, latch the word address, wdata and wstrb in the same cycle.
  - wstrb==0 or wstrb partial (neither 0 nor 4'hF) -> RD_ISSUE.
  - wstrb==4'hF -> WR.
  - No sel -> stay in IDLE.
- RD_ISSUE: ram_rd_en_o=1, ram_addr_o=latched address -> RD_CAPTURE.
- RD_CAPTURE:
  - ram_rd_en_o held at 1; ram_do_i is sampled.
  - Read: rdata_q <= ram_do_i -> ACK.
  - Partial write: merge_q[8k+7:8k] <= wstrb[k] ? wdata[8k+7:8k] : ram_do_i[8k+7:8k], for k=0..3 -> WR.
- WR: ram_wr_en_o=1 for exactly one cycle, ram_di_o = full wdata or merge_q -> ACK.
- ACK: mem_ready_o=1 for one cycle.
  - mem_rdata_o = rdata_q for reads, 0 for writes.
  - Next state is IDLE.
- Latency, counted from the IDLE sample edge T0 to the cycle mem_ready_o=1:
  - read: 3 cycles
  - full write: 2 cycles
  - partial write: 4 cycles
- ram_wr_en_o and ram_rd_en_o are never high together.
- ram_addr_o is stable from RD_ISSUE/WR through ACK.
- Outside RD_ISSUE/RD_CAPTURE/WR, both RAM enables are 0.
- Bus inputs are ignored outside IDLE. mem_valid_i dropping mid-transaction does not abort the transaction.
- After ACK, IDLE re-samples mem_valid_i. The master deasserts valid in the cycle after ready, so no duplicate issue occurs.
- Back-to-back requests: a new request can be accepted in the cycle after ACK.
- mem_addr_i[1:0] is ignored; accesses are word-aligned.
- Window boundary: the last word (2^ADDR_BIT-1) is selected. BASE_ADDR + 2^(ADDR_BIT+2) is not selected.

Optional Feature:
- USER_RAM_BRIDGE_ERR_EN defined:
  - A selected access with mem_addr_i[1:0]!=0 goes IDLE -> ACK directly; the RAM is not touched.
  - A misaligned read returns mem_rdata_o=32'hDEAD_BEEF.
  - A misaligned write is dropped.
  - err_o is set to 1 and stays set until reset.
- USER_RAM_BRIDGE_ERR_EN undefined:
  - err_o is absent.
  - Misaligned accesses are truncated to the word address and proceed normally.

Test Plan:
- After reset, full write 0x1234_5678 to BASE+0x10, then read it back. Write: ram_wr_en_o pulses at T1 with ram_addr_o=4, ready at T2. Read: ready at T3 with mem_rdata_o=0x1234_5678.
- Word BASE+0x20 holds 0xAABB_CCDD; write wdata 0x1122_3344 with wstrb 4'b0101. Sequence is rd, rd, wr; ram_di_o=0xAA22_CC44; ready at T4; read back returns 0xAA22_CC44.
- Access BASE + 2^(ADDR_BIT+2) for 10 cycles -> no mem_ready_o and no RAM enable. Access the last word -> served normally.
- Pull rst_i low during RD_CAPTURE of a partial write -> outputs go 0 immediately, no ram_wr_en_o pulse, target word unchanged.
- Issue three back-to-back reads to words 0, 1, 2 -> exactly three ready pulses, correct data each, rd_en and wr_en never overlap.
- With USER_RAM_BRIDGE_ERR_EN: read BASE+0x3 -> ready at T1, mem_rdata_o=0xDEAD_BEEF, err_o=1 and held. Then write BASE+0x5 -> no RAM write occurs.
